// File: rtl/operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_pkg
// Description : Shared widths and types for the operand fetch block.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_fetch_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;

  // Register indices are 4 bits wide, so the register count is pinned at 16.
  typedef logic [3:0]        reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage : operand_fetch_pkg
`default_nettype wire

// File: rtl/operand_fetch_onehot_encoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_encoder
// Description : Encodes a 16-bit write enable into an index and an active
//               bit, using lowest-set-bit priority, and flags vectors that
//               have more than one bit set.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_encoder
  import operand_fetch_pkg::*;
(
  input  logic [15:0] i_onehot,
  output reg_idx_t    o_idx,
  output logic        o_active,
  output logic        o_multi
);

  // Descending scan so the lowest set bit is the last to assign the index.
  always_comb begin
    o_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i_onehot[i]) begin
        o_idx = reg_idx_t'(i);
      end
    end
  end

  assign o_active = |i_onehot;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign o_multi  = (i_onehot & (i_onehot - 16'd1)) != 16'd0;

endmodule : onehot_encoder
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Reads two operands from a flattened register file into a
//               one-deep valid/ready output register, with optional write
//               forwarding at capture and while the pair is held.
//               Forwarding is enabled by defining OPERAND_FETCH_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = operand_fetch_pkg::DATA_W,
  parameter int NREGS  = operand_fetch_pkg::NREGS
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  reg_idx_t                rdest,
  input  reg_idx_t                rsrc,
  input  logic [NREGS*DATA_W-1:0] regs_flat,
  input  logic [15:0]             reg_wen_onehot,
  input  logic [DATA_W-1:0]       wdata,
  output logic                    op_valid,
  input  logic                    op_ready,
  output logic [DATA_W-1:0]       op_a,
  output logic [DATA_W-1:0]       op_b,
  output reg_idx_t                op_dest,
  output logic                    err_multi
);

  reg_idx_t          w_wen_idx;
  logic              w_wen_act;
  logic              w_wen_multi;
  logic              w_accept;
  logic [DATA_W-1:0] w_cap_a;
  logic [DATA_W-1:0] w_cap_b;

  logic              r_valid;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  reg_idx_t          r_dest;
  logic              r_err;

  onehot_encoder u_enc (
    .i_onehot (reg_wen_onehot),
    .o_idx    (w_wen_idx),
    .o_active (w_wen_act),
    .o_multi  (w_wen_multi)
  );

  // Ready reads high during reset; the reset branch discards any request.
  assign req_ready = reset || !r_valid || op_ready;
  assign w_accept  = req_valid && req_ready;

  // Operand read mux, with the in-flight write overriding the stale file value.
  always_comb begin
    w_cap_a = regs_flat[rdest * DATA_W +: DATA_W];
    w_cap_b = regs_flat[rsrc  * DATA_W +: DATA_W];
`ifdef OPERAND_FETCH_FWD_EN
    if (w_wen_act && (w_wen_idx == rdest)) w_cap_a = wdata;
    if (w_wen_act && (w_wen_idx == rsrc))  w_cap_b = wdata;
`endif
  end

`ifdef OPERAND_FETCH_FWD_EN
  // Source index is kept so a held op_b can track later writes to it.
  reg_idx_t r_src;

  // Output register: capture, drain, and forwarding into a held pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_dest  <= '0;
      r_src   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_wen_multi) r_err <= 1'b1;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_a     <= w_cap_a;
        r_b     <= w_cap_b;
        r_dest  <= rdest;
        r_src   <= rsrc;
      end else if (r_valid && op_ready) begin
        r_valid <= 1'b0;
      end else if (r_valid) begin
        if (w_wen_act && (w_wen_idx == r_dest)) r_a <= wdata;
        if (w_wen_act && (w_wen_idx == r_src))  r_b <= wdata;
      end
    end
  end
`else
  // Without forwarding wdata has no consumer; fold it into a sink.
  logic w_unused_wdata;
  assign w_unused_wdata = ^{wdata, w_wen_idx, w_wen_act};

  // Output register: capture and drain only; held values never change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_dest  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_wen_multi) r_err <= 1'b1;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_a     <= w_cap_a;
        r_b     <= w_cap_b;
        r_dest  <= rdest;
      end else if (r_valid && op_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
`endif

  assign op_valid  = r_valid;
  assign op_a      = r_a;
  assign op_b      = r_b;
  assign op_dest   = r_dest;
  assign err_multi = r_err;

endmodule : operand_fetch
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch: directed vectors, a
//               rule-level reference model compared every cycle, and literal
//               expectations at the key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   rdest;
  logic [3:0]   rsrc;
  logic [255:0] regs_flat;
  logic [15:0]  reg_wen_onehot;
  logic [15:0]  wdata;
  logic         op_valid;
  logic         op_ready;
  logic [15:0]  op_a;
  logic [15:0]  op_b;
  logic [3:0]   op_dest;
  logic         err_multi;

  logic [15:0]  regs [16];

  int n_vec = 0;
  int n_err = 0;

`ifdef OPERAND_FETCH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  operand_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .rdest          (rdest),
    .rsrc           (rsrc),
    .regs_flat      (regs_flat),
    .reg_wen_onehot (reg_wen_onehot),
    .wdata          (wdata),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_a           (op_a),
    .op_b           (op_b),
    .op_dest        (op_dest),
    .err_multi      (err_multi)
  );

  always #5 clk = ~clk;

  // Present the bench register array as the flat bus.
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < 16; i++) regs_flat[i*16 +: 16] = regs[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_init = 0;
  bit          m_zero;
  bit          m_valid;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_dest, m_src;
  bit          m_err;
  bit          t_wact, t_ready;
  int          t_widx;

  // Model of what the output register must hold after each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_valid = 0; m_a = 0; m_b = 0; m_dest = 0; m_src = 0; m_err = 0;
      m_zero = 1; m_init = 1;
    end else if (m_init) begin
      t_wact = 0; t_widx = 0;
      for (int i = 0; i < 16; i++)
        if (reg_wen_onehot[i] && !t_wact) begin t_wact = 1; t_widx = i; end
      if ($countones(reg_wen_onehot) >= 2) m_err = 1;
      t_ready = !m_valid || op_ready;
      if (req_valid && t_ready) begin
        m_a = regs[rdest];
        m_b = regs[rsrc];
        if (FWD && t_wact && t_widx == int'(rdest)) m_a = wdata;
        if (FWD && t_wact && t_widx == int'(rsrc))  m_b = wdata;
        m_dest = rdest; m_src = rsrc; m_valid = 1; m_zero = 0;
      end else if (m_valid && op_ready) begin
        m_valid = 0;
      end else if (m_valid && FWD && t_wact) begin
        if (t_widx == int'(m_dest)) m_a = wdata;
        if (t_widx == int'(m_src))  m_b = wdata;
      end
    end
  end

  // Compare DUT against the model on the falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      check("cmp_op_valid", {31'd0, op_valid}, {31'd0, m_valid});
      check("cmp_err_multi", {31'd0, err_multi}, {31'd0, m_err});
      check("cmp_req_ready", {31'd0, req_ready}, {31'd0, (reset || !m_valid || op_ready)});
      if (m_valid || m_zero) begin
        check("cmp_op_a", {16'd0, op_a}, {16'd0, m_a});
        check("cmp_op_b", {16'd0, op_b}, {16'd0, m_b});
        check("cmp_op_dest", {28'd0, op_dest}, {28'd0, m_dest});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1; req_valid = 1; rdest = 4'd1; rsrc = 4'd2;
    reg_wen_onehot = 16'h0; wdata = 16'h0; op_ready = 0;
    for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i) * 16'h0111;
    regs[3] = 16'h1234; regs[7] = 16'hBEEF; regs[5] = 16'h5555;
    regs[2] = 16'h2222; regs[0] = 16'h00AA;

    // Reset with a request present: it must be discarded.
    cyc(); cyc();
    check("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check("rst_op_a", {16'd0, op_a}, 32'd0);
    check("rst_err", {31'd0, err_multi}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    reset = 0; req_valid = 0;
    cyc();
    check("rst_discard", {31'd0, op_valid}, 32'd0);

    // Basic fetch.
    req_valid = 1; rdest = 4'd3; rsrc = 4'd7;
    cyc();
    req_valid = 0;
    check("basic_valid", {31'd0, op_valid}, 32'd1);
    check("basic_a", {16'd0, op_a}, 32'h1234);
    check("basic_b", {16'd0, op_b}, 32'hBEEF);
    check("basic_dest", {28'd0, op_dest}, 32'd3);
    check("basic_ready", {31'd0, req_ready}, 32'd0);
    op_ready = 1;
    cyc();
    op_ready = 0;
    check("drain_valid", {31'd0, op_valid}, 32'd0);

    // Capture forwarding to op_a.
    req_valid = 1; rdest = 4'd5; rsrc = 4'd7;
    reg_wen_onehot = 16'h0020; wdata = 16'hA5A5;
    cyc();
    req_valid = 0; reg_wen_onehot = 16'h0; regs[5] = 16'hA5A5;
    check("capfwd_a", {16'd0, op_a}, FWD ? 32'hA5A5 : 32'h5555);
    op_ready = 1;
    cyc();
    op_ready = 0;

    // Held-operand update of op_b.
    req_valid = 1; rdest = 4'd3; rsrc = 4'd2;
    cyc();
    req_valid = 0;
    check("hold_b_before", {16'd0, op_b}, 32'h2222);
    reg_wen_onehot = 16'h0004; wdata = 16'h0F0F;
    cyc();
    reg_wen_onehot = 16'h0; regs[2] = 16'h0F0F;
    check("hold_b_after", {16'd0, op_b}, FWD ? 32'h0F0F : 32'h2222);
    check("hold_ready", {31'd0, req_ready}, 32'd0);
    check("hold_a", {16'd0, op_a}, 32'h1234);

    // Back-to-back with consume + accept in the same cycle.
    op_ready = 1; req_valid = 1;
    for (int i = 0; i < 6; i++) begin
      rdest = 4'(i); rsrc = 4'(15 - i);
      cyc();
      check("b2b_valid", {31'd0, op_valid}, 32'd1);
      check("b2b_a", {16'd0, op_a}, {16'd0, regs[i]});
      check("b2b_b", {16'd0, op_b}, {16'd0, regs[15 - i]});
    end
    req_valid = 0;
    cyc();
    check("b2b_end", {31'd0, op_valid}, 32'd0);

    // Both operands forward when rdest == rsrc.
    req_valid = 1; rdest = 4'd9; rsrc = 4'd9;
    reg_wen_onehot = 16'h0200; wdata = 16'h9999;
    cyc();
    req_valid = 0; reg_wen_onehot = 16'h0;
    check("same_a", {16'd0, op_a}, FWD ? 32'h9999 : {16'd0, regs[9]});
    check("same_b", {16'd0, op_b}, FWD ? 32'h9999 : {16'd0, regs[9]});
    regs[9] = 16'h9999;
    cyc();

    // Multi-hot write: error flag, lowest bit wins for forwarding.
    req_valid = 1; rdest = 4'd0; rsrc = 4'd3;
    reg_wen_onehot = 16'h0009; wdata = 16'h7777;
    cyc();
    req_valid = 0; reg_wen_onehot = 16'h0;
    check("multi_err", {31'd0, err_multi}, 32'd1);
    check("multi_a", {16'd0, op_a}, FWD ? 32'h7777 : 32'h00AA);
    check("multi_b", {16'd0, op_b}, 32'h1234);
    cyc(); cyc();
    check("multi_sticky", {31'd0, err_multi}, 32'd1);
    reset = 1;
    cyc();
    reset = 0;
    check("multi_clear", {31'd0, err_multi}, 32'd0);

    // Reset during a hold drops the pair.
    op_ready = 0; req_valid = 1; rdest = 4'd7; rsrc = 4'd3;
    cyc();
    req_valid = 0;
    cyc();
    check("rhold_valid", {31'd0, op_valid}, 32'd1);
    check("rhold_a", {16'd0, op_a}, 32'hBEEF);
    reset = 1;
    cyc();
    reset = 0;
    check("rhold_v0", {31'd0, op_valid}, 32'd0);
    check("rhold_a0", {16'd0, op_a}, 32'd0);
    check("rhold_b0", {16'd0, op_b}, 32'd0);
    check("rhold_d0", {28'd0, op_dest}, 32'd0);
    cyc();
    check("rhold_gone", {31'd0, op_valid}, 32'd0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_operand_fetch
`default_nettype wire
